// File: rtl/lbp_pkg.sv
// Purpose: shared constants, FSM state encoding and neighbour bit ordering for the LBP core.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lbp_pkg;

    // Default image geometry: square IMG_W x IMG_W image, ADDR_W = log2(IMG_W*IMG_W).
    localparam int IMG_W  = 128;
    localparam int ADDR_W = 14;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        WRITE,
        NEXT,
        DONE
    } state_t;

    // The 3x3 window is flattened as slot = row*3 + col, where row 0 is r-1 and col 0 is c-1.
    // The centre sits in slot 4.
    localparam logic [3:0] CENTRE_POS = 4'd4;

    // Window slot of the neighbour that drives code bit b.
    // Bits 0..3 map to slots 0..3 and bits 4..7 to slots 5..8, so the centre is skipped.
    function automatic logic [3:0] nb_pos(input logic [2:0] b);
        return (b < 3'd4) ? {1'b0, b} : ({1'b0, b} + 4'd1);
    endfunction

endpackage

// File: rtl/lbp_code.sv
// Purpose: combinational LBP code from a flattened 3x3 pixel window.
// Latency: 0 cycles (purely combinational).
// Backpressure: none.
// Ports: pix  - nine 8-bit pixels, slot = row*3 + col, centre in slot 4
//        code - 8-bit code; a bit is set when its neighbour >= centre (unsigned)
module lbp_code
    import lbp_pkg::*;
(
    input  logic [8:0][7:0] pix,
    output logic [7:0]      code
);

    always_comb begin
        code = '0;
        for (int b = 0; b < 8; b++) begin
            code[b] = (pix[nb_pos(3'(b))] >= pix[CENTRE_POS]);
        end
    end

endmodule

// File: rtl/lbp_core.sv
// Purpose: LBP image engine; reads grayscale pixels through a 3x3 register window, writes codes for interior pixels.
// Latency: 12 cycles for the first centre of each row (9 reads), 6 cycles for every following centre (3 reads).
// Backpressure: none; waits in IDLE until gray_ready, then streams one read per cycle.
// Ports: clk/reset (sync, active-low); gray_ready/gray_req/gray_addr/gray_data read side;
//        lbp_valid/lbp_addr/lbp_data write side (memory writes on falling edge); finish = image done.
module lbp_core
#(
    parameter int IMG_W  = lbp_pkg::IMG_W,
    parameter int ADDR_W = lbp_pkg::ADDR_W
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              gray_ready,
    output logic              gray_req,
    output logic [ADDR_W-1:0] gray_addr,
    input  logic [7:0]        gray_data,
    output logic              lbp_valid,
    output logic [ADDR_W-1:0] lbp_addr,
    output logic [7:0]        lbp_data,
    output logic              finish
);

    import lbp_pkg::*;

    localparam logic [ADDR_W-1:0] ONE     = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(IMG_W - 2);
    localparam logic [ADDR_W-1:0] IMG_W_A = ADDR_W'(IMG_W);

    state_t            state;
    logic [ADDR_W-1:0] row;        // current centre row
    logic [ADDR_W-1:0] col;        // current centre column
    logic [1:0]        iss_row;    // window row of the next read to issue
    logic [1:0]        iss_col;    // window column of the next read to issue
    logic              iss_done;   // all reads for this centre issued
    logic [3:0]        cap_slot;   // window slot the data now on gray_data belongs to
    logic [8:0][7:0]   win;        // slot = row*3 + col, centre in slot 4
    logic [7:0]        code;
    logic [ADDR_W-1:0] rd_row;
    logic [ADDR_W-1:0] rd_col;

    function automatic logic [ADDR_W-1:0] pix_addr(input logic [ADDR_W-1:0] r,
                                                   input logic [ADDR_W-1:0] c);
        return r * IMG_W_A + c;
    endfunction

    // Image coordinates of the next read: window (0,0) is pixel (row-1, col-1).
    assign rd_row = row - ONE + ADDR_W'(iss_row);
    assign rd_col = col - ONE + ADDR_W'(iss_col);

    lbp_code u_code (
        .pix  (win),
        .code (code)
    );

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            row       <= '0;
            col       <= '0;
            iss_row   <= '0;
            iss_col   <= '0;
            iss_done  <= 1'b0;
            cap_slot  <= '0;
            win       <= '0;
            gray_req  <= 1'b0;
            gray_addr <= '0;
            lbp_valid <= 1'b0;
            lbp_addr  <= '0;
            lbp_data  <= '0;
            finish    <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gray_ready) begin
                        row      <= ONE;
                        col      <= ONE;
                        iss_row  <= '0;
                        iss_col  <= '0;
                        iss_done <= 1'b0;
                        state    <= LOAD;
                    end
                end

                LOAD: begin
                    // Data for the address issued on the previous edge arrives now.
                    if (gray_req) begin
                        win[cap_slot] <= gray_data;
                    end
                    if (!iss_done) begin
                        gray_req  <= 1'b1;
                        gray_addr <= pix_addr(rd_row, rd_col);
                        cap_slot  <= 4'(iss_row) * 4'd3 + 4'(iss_col);
                        // Walk down a column, then move right; a full load starts at
                        // column 0, a shifted window only refills column 2.
                        if (iss_row == 2'd2) begin
                            iss_row <= '0;
                            if (iss_col == 2'd2) begin
                                iss_done <= 1'b1;
                            end else begin
                                iss_col <= iss_col + 2'd1;
                            end
                        end else begin
                            iss_row <= iss_row + 2'd1;
                        end
                    end else begin
                        // Last read is captured on this edge; the window is complete next cycle.
                        gray_req <= 1'b0;
                        state    <= WRITE;
                    end
                end

                WRITE: begin
                    // Strobe is registered, so it is visible for the single cycle that follows.
                    lbp_valid <= 1'b1;
                    lbp_addr  <= pix_addr(row, col);
                    lbp_data  <= code;
                    state     <= NEXT;
                end

                NEXT: begin
                    lbp_valid <= 1'b0;
                    iss_row   <= '0;
                    iss_done  <= 1'b0;
                    if (col == LAST) begin
                        if (row == LAST) begin
                            finish <= 1'b1;
                            state  <= DONE;
                        end else begin
                            row     <= row + ONE;
                            col     <= ONE;
                            iss_col <= 2'd0;
                            state   <= LOAD;
                        end
                    end else begin
                        col     <= col + ONE;
                        iss_col <= 2'd2;
                        // Slide the window left; column 2 is refilled by the next LOAD.
                        win[0]  <= win[1];
                        win[1]  <= win[2];
                        win[3]  <= win[4];
                        win[4]  <= win[5];
                        win[6]  <= win[7];
                        win[7]  <= win[8];
                        state   <= LOAD;
                    end
                end

                DONE: begin
                    finish <= 1'b1;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lbp_core.sv
// Purpose: self-checking bench for lbp_core on a 16x16 image with a write scoreboard.
// Latency: n/a (testbench).
// Backpressure: n/a (testbench).
module tb_lbp_core;

    localparam int W    = 16;
    localparam int AW   = 8;
    localparam int N    = W * W;
    localparam int LAST = (W - 2) * W + (W - 2);
    localparam int MID  = 8 * W + 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          gray_ready = 1'b0;
    logic          gray_req;
    logic [AW-1:0] gray_addr;
    logic [7:0]    gray_data;
    logic          lbp_valid;
    logic [AW-1:0] lbp_addr;
    logic [7:0]    lbp_data;
    logic          finish;

    logic [7:0] gray_mem [N];
    logic [7:0] res_mem  [N];

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [7:0]    data;
    } wr_t;

    wr_t exp_q[$];
    int  checks = 0;
    int  errors = 0;

    always #5 clk = ~clk;

    assign gray_data = gray_mem[gray_addr];

    lbp_core #(
        .IMG_W  (W),
        .ADDR_W (AW)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .gray_ready (gray_ready),
        .gray_req   (gray_req),
        .gray_addr  (gray_addr),
        .gray_data  (gray_data),
        .lbp_valid  (lbp_valid),
        .lbp_addr   (lbp_addr),
        .lbp_data   (lbp_data),
        .finish     (finish)
    );

    task automatic chk(input string name, input int unsigned act, input int unsigned exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Hand-derived expected codes: constant image -> FF, pixel=row -> F8,
    // spike at (5,5) -> 00 at the spike, FF everywhere else; borders stay 0.
    function automatic logic [7:0] exp_code(input int pat, input int r, input int c);
        if (r < 1 || r > W - 2 || c < 1 || c > W - 2) return 8'h00;
        case (pat)
            0:       return 8'hFF;
            1:       return 8'hF8;
            default: return (r == 5 && c == 5) ? 8'h00 : 8'hFF;
        endcase
    endfunction

    task automatic push_all(input int pat);
        wr_t e;
        exp_q.delete();
        for (int r = 1; r <= W - 2; r++) begin
            for (int c = 1; c <= W - 2; c++) begin
                e.addr = AW'(r * W + c);
                e.data = exp_code(pat, r, c);
                exp_q.push_back(e);
            end
        end
    endtask

    // Scoreboard monitor: models the result memory and checks every write in order.
    always @(negedge clk) begin
        wr_t e;
        if (lbp_valid === 1'b1) begin
            res_mem[lbp_addr] = lbp_data;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_write: addr 0x%0h data 0x%0h, no write expected", lbp_addr, lbp_data);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", lbp_addr, e.addr);
                chk("wr_data", lbp_data, e.data);
            end
        end
    end

    task automatic run_image(input int pat, input int idle_cyc, input bit mid_reset);
        int  req_cnt;
        int  bad;
        bit  seen;
        for (int a = 0; a < N; a++) begin
            case (pat)
                0:       gray_mem[a] = 8'h37;
                1:       gray_mem[a] = 8'(a / W);
                default: gray_mem[a] = (a == 5 * W + 5) ? 8'd200 : 8'd10;
            endcase
            res_mem[a] = 8'h00;
        end
        gray_ready = 1'b0;
        reset      = 1'b0;
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("reset_outputs", {gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}, 0);
        push_all(pat);
        reset = 1'b1;

        req_cnt = 0;
        for (int i = 0; i < idle_cyc; i++) begin
            @(posedge clk);
            #1;
            if (gray_req !== 1'b0) req_cnt++;
        end
        if (idle_cyc > 0) chk("idle_no_req", req_cnt, 0);
        gray_ready = 1'b1;

        if (mid_reset) begin
            seen = 1'b0;
            for (int i = 0; i < 5000; i++) begin
                @(negedge clk);
                if (lbp_valid === 1'b1 && lbp_addr == AW'(MID)) begin
                    seen = 1'b1;
                    break;
                end
            end
            chk("mid_row_reached", seen, 1);
            reset = 1'b0;
            @(posedge clk);
            #1;
            chk("mid_reset_outputs", {gray_req, gray_addr, lbp_valid, lbp_addr, lbp_data, finish}, 0);
            @(posedge clk);
            #1;
            push_all(pat);
            reset = 1'b1;
        end

        seen = 1'b0;
        for (int i = 0; i < 5000; i++) begin
            @(negedge clk);
            if (lbp_valid === 1'b1 && lbp_addr == AW'(LAST)) begin
                seen = 1'b1;
                break;
            end
        end
        chk("last_write_seen", seen, 1);
        chk("finish_low_at_last", finish, 0);
        @(negedge clk);
        chk("finish_after_last", finish, 1);
        repeat (3) @(negedge clk);
        chk("done_quiet", {gray_req, lbp_valid, finish}, 3'b001);
        chk("all_writes_seen", exp_q.size(), 0);
        bad = 0;
        for (int a = 0; a < N; a++) begin
            if (res_mem[a] !== exp_code(pat, a / W, a % W)) bad++;
        end
        chk("image_match", bad, 0);
    endtask

    initial begin
        run_image(0, 0, 1'b0);   // constant 0x37
        run_image(1, 0, 1'b0);   // pixel = row index
        run_image(2, 50, 1'b0);  // spike, with gray_ready held low first
        run_image(1, 0, 1'b1);   // reset pulse in row 8, then full rerun
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/lbp_core.md
LBP_CORE -- requirements
Module: lbp_core

Interface
REQ-001 Parameter IMG_W, default 128, image width and height in pixels (square image).
REQ-002 Parameter ADDR_W, default 14, pixel address width (log2 of IMG_W*IMG_W).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 reset  input  1  synchronous, active-low reset, sampled on the rising edge of clk.
REQ-005 gray_ready  input  1  high when the grayscale source memory is available.
REQ-006 gray_req  output  1  read request; gray_addr is valid while this is high.
REQ-007 gray_addr  output  ADDR_W  grayscale read address, row*IMG_W+col.
REQ-008 gray_data  input  8  pixel value for the current gray_addr; valid before the next rising edge while gray_req is high.
REQ-009 lbp_valid  output  1  write strobe; the result memory writes lbp_data at lbp_addr on the falling edge of clk while this is high.
REQ-010 lbp_addr  output  ADDR_W  result address, row*IMG_W+col.
REQ-011 lbp_data  output  8  LBP code.
REQ-012 finish  output  1  high when the whole image is processed.

Function
REQ-013 The block SHALL remain idle, with gray_req low, until gray_ready is sampled high.
REQ-014 Read timing: gray_addr and gray_req are driven from a rising edge, and gray_data is captured on the next rising edge, giving one pixel per cycle.
REQ-015 Centre pixels: rows 1..IMG_W-2 and columns 1..IMG_W-2 only; border pixels SHALL NOT be written, because the result memory is zero-initialised.
REQ-016 Neighbour weights for centre (r,c):
  - (r-1,c-1)=bit0, (r-1,c)=bit1, (r-1,c+1)=bit2
  - (r,c-1)=bit3, (r,c+1)=bit4
  - (r+1,c-1)=bit5, (r+1,c)=bit6, (r+1,c+1)=bit7
REQ-017 Each bit SHALL be 1 when the neighbour is greater than or equal to the centre (unsigned 8-bit compare), otherwise 0.
REQ-018 Window: a 3x3 register window; no line buffers are used.
  - At the start of each row r, read the 9 pixels of columns 0..2, rows r-1..r+1.
  - For each subsequent centre, shift the window left and read 3 pixels of column c+1, rows r-1, r, r+1.
REQ-019 FSM states SHALL be IDLE, LOAD (reads), WRITE (compute and strobe), NEXT (advance column/row) and DONE.
  - IDLE->LOAD on gray_ready.
  - LOAD->WRITE once the required reads are captured.
  - WRITE->NEXT after a one-cycle strobe.
  - NEXT->LOAD while centres remain.
  - NEXT->DONE after centre (IMG_W-2, IMG_W-2).
REQ-020 In WRITE, lbp_valid SHALL be high for exactly one cycle, with lbp_addr=r*IMG_W+c and lbp_data equal to the code for that centre.
REQ-021 Centres SHALL be processed in raster order; the first write is to address 129 and the last to address 16254 (defaults).
REQ-022 finish SHALL rise on the cycle after the last write and stay high until reset; in DONE, gray_req and lbp_valid SHALL stay low.
REQ-023 Address arithmetic is ADDR_W bits wide and never wraps, since all addresses are within 0..IMG_W*IMG_W-1.

Reset
REQ-024 While reset is low at a rising edge, the block SHALL force IDLE and clear all counters and window registers, with outputs as follows: gray_req=0, gray_addr=0, lbp_valid=0, lbp_addr=0, lbp_data=0, finish=0.
REQ-025 Reset asserted mid-image SHALL abort processing; after release, the block restarts from centre (1,1).

Structure
REQ-026 A shared package SHALL hold IMG_W, ADDR_W, the FSM state enumeration, and the neighbour bit-weight ordering.
REQ-027 One sub-module lbp_code SHALL be used: purely combinational, taking 9 pixels and producing the 8-bit code.
REQ-028 The FSM, counters and window SHALL reside in lbp_core.

Verification
REQ-029 Constant image (all pixels 0x37) -> every interior address holds 0xFF and every border address holds 0x00.
REQ-030 Pixel value = row index -> every interior address holds 0xF8 (upper row less, own row equal, lower row greater).
REQ-031 Image all 10 except (5,5)=200 -> results:
  - address 645 holds 0x00
  - address 516 holds 0xFF (bit7 neighbour 200 >= 10)
  - all other interior addresses hold 0xFF
REQ-032 gray_ready held low for 50 cycles after reset -> no gray_req during that time; then normal completion with correct results.
REQ-033 Reset pulsed low for 2 cycles while processing row 40 -> all outputs are 0 on the next edge; the run then completes and matches the golden image, and finish is high one cycle after the write to address 16254.
